// File: rtl/mem_access_unit_if.sv
// Wishbone classic data-bus bundle between the MEM-stage access unit (master)
// and the data memory / peripheral fabric (slave).
interface mem_access_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    wb_cyc_o;
  logic                    wb_stb_o;
  logic                    wb_we_o;
  logic                    wb_ack_i;
  logic [ADDR_WIDTH-1:0]   wb_adr_o;
  logic [DATA_WIDTH-1:0]   wb_dat_o;
  logic [DATA_WIDTH-1:0]   wb_dat_i;
  logic [DATA_WIDTH/8-1:0] wb_sel_o;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    input  wb_ack_i, wb_dat_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    output wb_ack_i, wb_dat_i
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage Wishbone classic master: one bus transaction per load/store, aligned
// sign-extended load data. Optional ack timeout enabled by MEM_ACCESS_TIMEOUT_EN.
module mem_access_unit #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_read_i,
  input  logic                  mem_write_i,
  input  logic                  mem_size_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [DATA_WIDTH-1:0] mem_wdata_i,
  output logic [DATA_WIDTH-1:0] mem_rdata_o,
  output logic                  stall_o,
  output logic                  bus_err_o,
  mem_access_unit_if.master     wb
);

  localparam int SEL_W = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t     state_q, state_d;
  logic       req;
  logic       launch;
  logic       ack_busy;
  logic       timeout_hit;
  logic       size_q;
  logic [1:0] lane_q;

  function automatic logic [SEL_W-1:0] lane_sel(input logic size, input logic [1:0] lane);
    return size ? {SEL_W{1'b1}} : (SEL_W'(1) << lane);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] lane_data(input logic size,
                                                      input logic [DATA_WIDTH-1:0] wdata);
    return size ? wdata : {SEL_W{wdata[7:0]}};
  endfunction

  // Byte loads pick the addressed lane and sign-extend it through a signed cast.
  function automatic logic [DATA_WIDTH-1:0] load_align(input logic size,
                                                       input logic [1:0] lane,
                                                       input logic [DATA_WIDTH-1:0] rdata);
    logic signed [7:0]            lane_byte;
    logic signed [DATA_WIDTH-1:0] lane_ext;
    lane_byte = rdata[{lane, 3'b000} +: 8];
    lane_ext  = DATA_WIDTH'(lane_byte);
    return size ? rdata : lane_ext;
  endfunction

  assign req = mem_read_i | mem_write_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = BUSY;
      BUSY:    if (wb.wb_ack_i || timeout_hit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // DONE releases the stall so EX/MEM and MEM/WB advance at the closing edge.
  always_comb begin
    stall_o  = req && (state_q != DONE);
    launch   = (state_q == IDLE) && req;
    ack_busy = (state_q == BUSY) && wb.wb_ack_i;
  end

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] wait_cnt_q;
  logic             bus_err_q;

  // Counter sits at zero outside BUSY, so it starts clean on every entry.
  always_ff @(posedge clk) begin
    if (reset || (state_q != BUSY)) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_q + 1'b1;
    end
  end

  assign timeout_hit = (state_q == BUSY) && !wb.wb_ack_i &&
                       (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= timeout_hit;
    end
  end

  assign bus_err_o = bus_err_q;
`else
  assign timeout_hit = 1'b0;
  assign bus_err_o   = 1'b0;
`endif

  // Bus outputs are flops; cyc/stb follow the next state so they drop with ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb.wb_cyc_o <= 1'b0;
      wb.wb_stb_o <= 1'b0;
      wb.wb_we_o  <= 1'b0;
      wb.wb_adr_o <= '0;
      wb.wb_dat_o <= '0;
      wb.wb_sel_o <= '0;
      size_q      <= 1'b0;
      lane_q      <= 2'b00;
    end else begin
      wb.wb_cyc_o <= (state_d == BUSY);
      wb.wb_stb_o <= (state_d == BUSY);
      if (launch) begin
        wb.wb_adr_o <= {mem_addr_i[ADDR_WIDTH-1:2], 2'b00};
        wb.wb_sel_o <= lane_sel(mem_size_i, mem_addr_i[1:0]);
        wb.wb_dat_o <= lane_data(mem_size_i, mem_wdata_i);
        wb.wb_we_o  <= mem_write_i;
        size_q      <= mem_size_i;
        lane_q      <= mem_addr_i[1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_rdata_o <= '0;
    end else if (ack_busy && !wb.wb_we_o) begin
      mem_rdata_o <= load_align(size_q, lane_q, wb.wb_dat_i);
    end else if (timeout_hit && !wb.wb_we_o) begin
      mem_rdata_o <= '0;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: transaction-level expectations are kept in
// model variables and checked every cycle; literal values pin the key cases.
module tb_mem_access_unit;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rd = 1'b0, wr = 1'b0, sz = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] rdata;
  logic          stall, err;

  mem_access_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) wb ();

  mem_access_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_read_i  (rd),
    .mem_write_i (wr),
    .mem_size_i  (sz),
    .mem_addr_i  (addr),
    .mem_wdata_i (wdata),
    .mem_rdata_o (rdata),
    .stall_o     (stall),
    .bus_err_o   (err),
    .wb          (wb)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  logic        m_on = 1'b0;
  logic        m_cyc = 1'b0, m_stall = 1'b0, m_err = 1'b0, m_we = 1'b0;
  logic [31:0] m_rdata = '0, m_adr = '0, m_dat = '0;
  logic [3:0]  m_sel = '0;

  int          stall_cnt = 0, cyc_cnt = 0, cyc_rise = 0, err_cnt = 0;
  logic        prev_cyc = 1'b0;
  logic [31:0] seen_adr = '0, seen_dat = '0;
  logic [3:0]  seen_sel = '0;
  logic        seen_we = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_load(input logic s, input logic [31:0] a,
                                           input logic [31:0] d);
    logic [31:0] b;
    if (s) return d;
    b = (d >> (8 * a[1:0])) & 32'hFF;
    return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
  endfunction

  // Inputs change at negedge; everything is sampled 2 ns later in the same cycle.
  always begin
    @(negedge clk);
    #2;
    if (m_on) begin
      chk("cyc", wb.wb_cyc_o, m_cyc);
      chk("stb", wb.wb_stb_o, m_cyc);
      chk("stall", stall, m_stall);
      chk("rdata", rdata, m_rdata);
      chk("bus_err", err, m_err);
      if (m_cyc) begin
        chk("adr", wb.wb_adr_o, m_adr);
        chk("sel", wb.wb_sel_o, m_sel);
        chk("dat", wb.wb_dat_o, m_dat);
        chk("we", wb.wb_we_o, m_we);
      end
    end
    if (wb.wb_cyc_o === 1'b1) begin
      cyc_cnt++;
      seen_adr = wb.wb_adr_o;
      seen_sel = wb.wb_sel_o;
      seen_dat = wb.wb_dat_o;
      seen_we  = wb.wb_we_o;
      if (prev_cyc !== 1'b1) cyc_rise++;
    end
    if (stall === 1'b1) stall_cnt++;
    if (err === 1'b1) err_cnt++;
    prev_cyc = wb.wb_cyc_o;
  end

  task automatic clear_obs();
    stall_cnt = 0; cyc_cnt = 0; cyc_rise = 0; err_cnt = 0;
  endtask

  task automatic idle();
    @(negedge clk);
    rd = 1'b0; wr = 1'b0; wb.wb_ack_i = 1'b0;
    m_cyc = 1'b0; m_stall = 1'b0; m_err = 1'b0;
  endtask

  // One access starting in IDLE, slave acks after k wait states; returns at the
  // negedge of the completion cycle with the request still presented.
  task automatic access(input logic r, input logic w, input logic s, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] slave_d, input int k,
                        input logic scramble);
    @(negedge clk);
    rd = r; wr = w; sz = s; addr = a; wdata = wd; wb.wb_ack_i = 1'b0;
    m_cyc = 1'b0; m_stall = 1'b1; m_err = 1'b0;
    m_adr = a & ~32'h3;
    m_sel = s ? 4'hF : (4'b0001 << a[1:0]);
    m_dat = s ? wd : {4{wd[7:0]}};
    m_we  = w;
    for (int t = 0; t <= k; t++) begin
      @(negedge clk);
      m_cyc = 1'b1; m_stall = 1'b1;
      wb.wb_ack_i = (t == k);
      wb.wb_dat_i = (t == k) ? slave_d : 32'h5A5A_5A5A;
      if (scramble) begin
        addr = ~a; wdata = ~wd; sz = ~s;
      end
    end
    @(negedge clk);
    wb.wb_ack_i = 1'b0;
    m_cyc = 1'b0; m_stall = 1'b0;
    if (!w) m_rdata = exp_load(s, a, slave_d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    wb.wb_ack_i = 1'b0;
    wb.wb_dat_i = '0;
    repeat (3) @(negedge clk);
    m_on = 1'b1;
    #3;
    chk("rst_adr", wb.wb_adr_o, 32'h0);
    chk("rst_sel", wb.wb_sel_o, 32'h0);
    chk("rst_dat", wb.wb_dat_o, 32'h0);
    chk("rst_we", wb.wb_we_o, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Word load, zero wait states
    idle(); clear_obs();
    access(1'b1, 1'b0, 1'b1, 32'h8000_0104, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);
    idle(); #3;
    chk("wl_stall_cycles", stall_cnt, 2);
    chk("wl_adr", seen_adr, 32'h8000_0104);
    chk("wl_sel", seen_sel, 4'hF);
    chk("wl_we", seen_we, 1'b0);
    chk("wl_rdata", rdata, 32'hDEAD_BEEF);

    // Byte loads with sign extension
    access(1'b1, 1'b0, 1'b0, 32'h8000_0203, 32'h0, 32'h8000_007F, 1, 1'b0);
    idle(); #3;
    chk("bl3_sel", seen_sel, 4'b1000);
    chk("bl3_rdata", rdata, 32'hFFFF_FF80);
    access(1'b1, 1'b0, 1'b0, 32'h8000_0200, 32'h0, 32'h8000_007F, 0, 1'b0);
    idle(); #3;
    chk("bl0_sel", seen_sel, 4'b0001);
    chk("bl0_rdata", rdata, 32'h0000_007F);

    // Byte store, 3 wait states, request inputs scrambled while busy
    clear_obs();
    access(1'b0, 1'b1, 1'b0, 32'h1000_0001, 32'h0000_0041, 32'hFFFF_FFFF, 3, 1'b1);
    idle(); #3;
    chk("bs_adr", seen_adr, 32'h1000_0000);
    chk("bs_sel", seen_sel, 4'b0010);
    chk("bs_dat", seen_dat, 32'h4141_4141);
    chk("bs_we", seen_we, 1'b1);
    chk("bs_cyc_cycles", cyc_cnt, 4);
    chk("bs_rdata_kept", rdata, 32'h0000_007F);

    // Read and write together behave as a write
    access(1'b1, 1'b1, 1'b0, 32'h3000_0002, 32'hFFFF_FF99, 32'h1234_5678, 0, 1'b0);
    idle(); #3;
    chk("rw_we", seen_we, 1'b1);
    chk("rw_sel", seen_sel, 4'b0100);
    chk("rw_dat", seen_dat, 32'h9999_9999);
    chk("rw_rdata_kept", rdata, 32'h0000_007F);

    // Back-to-back store then load
    clear_obs();
    access(1'b0, 1'b1, 1'b1, 32'h2000_0008, 32'h1234_5678, 32'h0, 1, 1'b0);
    access(1'b1, 1'b0, 1'b1, 32'h2000_000C, 32'h0, 32'hCAFE_F00D, 0, 1'b0);
    idle(); #3;
    chk("b2b_cyc_rises", cyc_rise, 2);
    chk("b2b_cyc_cycles", cyc_cnt, 3);
    chk("b2b_rdata", rdata, 32'hCAFE_F00D);

    // Reset while BUSY, then a late ack
    @(negedge clk);
    rd = 1'b1; wr = 1'b0; sz = 1'b1; addr = 32'h4000_0000;
    m_stall = 1'b1; m_cyc = 1'b0; m_adr = 32'h4000_0000; m_sel = 4'hF; m_we = 1'b0;
    @(negedge clk);
    m_cyc = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; rd = 1'b0;
    m_cyc = 1'b0; m_stall = 1'b0; m_rdata = 32'h0;
    wb.wb_ack_i = 1'b1; wb.wb_dat_i = 32'h1122_3344;
    #3;
    chk("rst_busy_we", wb.wb_we_o, 1'b0);
    idle(); idle(); #3;
    chk("late_ack_rdata", rdata, 32'h0);
    chk("late_ack_cyc", wb.wb_cyc_o, 1'b0);

`ifdef MEM_ACCESS_TIMEOUT_EN
    access(1'b1, 1'b0, 1'b0, 32'h5000_0011, 32'h0, 32'h0000_2200, 0, 1'b0);
    idle(); clear_obs();
    @(negedge clk);
    rd = 1'b1; wr = 1'b0; sz = 1'b1; addr = 32'h6000_0000;
    m_stall = 1'b1; m_cyc = 1'b0; m_adr = 32'h6000_0000; m_sel = 4'hF; m_we = 1'b0;
    for (int t = 0; t < TO; t++) begin
      @(negedge clk);
      m_cyc = 1'b1;
    end
    @(negedge clk);
    m_cyc = 1'b0; m_stall = 1'b0; m_err = 1'b1; m_rdata = 32'h0;
    idle(); #3;
    chk("to_cyc_cycles", cyc_cnt, TO);
    chk("to_err_pulses", err_cnt, 1);
    chk("to_rdata", rdata, 32'h0);
`else
    clear_obs();
    access(1'b1, 1'b0, 1'b1, 32'h5000_0010, 32'h0, 32'h0BAD_C0DE, 20, 1'b0);
    idle(); #3;
    chk("long_cyc_cycles", cyc_cnt, 21);
    chk("long_err_pulses", err_cnt, 0);
    chk("long_rdata", rdata, 32'h0BAD_C0DE);
`endif

    idle();
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
